// File: rtl/lbuf_pkg.sv
// Shared definitions for the 3x3 binary-window line buffer: controller state encoding,
// default counter width and window output latency.
package lbuf_pkg;

    localparam int unsigned CNT_W_DEF = 11;
    localparam int unsigned WIN_LAT   = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } lbuf_state_e;

endpackage

// File: rtl/video_edge_det.sv
// Registered edge detection for the pre-window frame-valid and line-valid strobes.
module video_edge_det (
    input  logic clk,
    input  logic vs,
    input  logic hs,
    output logic vs_rise,
    output logic vs_fall,
    output logic hs_fall
);

    logic vs_q;
    logic hs_q;

    // The copies track the inputs even through reset, so a frame already in progress at
    // reset release is not mistaken for a fresh frame start.
    always_ff @(posedge clk) begin
        vs_q <= vs;
        hs_q <= hs;
    end

    assign vs_rise = vs & ~vs_q;
    assign vs_fall = ~vs & vs_q;
    assign hs_fall = ~hs & hs_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencing controller for the 3x3 binary-window line buffer: position tracking, shift-RAM
// clear and window flags. Define LBUF_CTRL_LEN_CHECK_EN to enable line/frame length checking.
module line_buffer_ctrl
    import lbuf_pkg::*;
#(
    parameter int unsigned IMG_H = 640,
    parameter int unsigned IMG_V = 480,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_vs,
    input  logic             pre_hs,
    input  logic             pre_clken,
    output logic             lbuf_clr,
    output logic             win_valid,
    output logic             win_border,
    output logic [CNT_W-1:0] win_col,
    output logic [CNT_W-1:0] win_row,
    output logic             frame_done,
    output logic [1:0]       state_o,
    output logic             err_len
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic             vs_rise;
    logic             vs_fall;
    logic             hs_fall;
    logic             beat;
    logic             line_end;
    lbuf_state_e      state_q;
    lbuf_state_e      state_d;
    logic [CNT_W-1:0] col_cnt_q;
    logic [CNT_W-1:0] row_cnt_q;
    logic             v1_q;
    logic             beat1_q;
    logic [CNT_W-1:0] col1_q;
    logic [CNT_W-1:0] row1_q;

    video_edge_det u_edge (
        .clk     (clk),
        .vs      (pre_vs),
        .hs      (pre_hs),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hs_fall (hs_fall)
    );

    assign beat = pre_hs & pre_clken;
    // Lines without any accepted pixel do not advance the row count.
    assign line_end = hs_fall & (col_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst || vs_rise) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            if (hs_fall) begin
                col_cnt_q <= '0;
            end else if (beat && col_cnt_q != CntMax) begin
                col_cnt_q <= col_cnt_q + CntOne;
            end
            if (line_end && row_cnt_q != CntMax) begin
                row_cnt_q <= row_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = StFill;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StFill: begin
                    if (line_end && row_cnt_q == CntOne) begin
                        state_d = StRun;
                    end else if (vs_fall) begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    if (line_end && row_cnt_q == CNT_W'(IMG_V - 1)) begin
                        state_d = StDone;
                    end else if (vs_fall) begin
                        state_d = StIdle;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Two register stages so the flags line up with the matrix outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            beat1_q    <= 1'b0;
            col1_q     <= '0;
            row1_q     <= '0;
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            lbuf_clr   <= 1'b0;
        end else begin
            v1_q       <= (state_q == StRun) & beat & (col_cnt_q >= CNT_W'(2));
            beat1_q    <= beat;
            if (beat) begin
                col1_q <= col_cnt_q - CntOne;
                row1_q <= row_cnt_q - CntOne;
            end
            win_valid  <= v1_q;
            win_border <= beat1_q & ~v1_q;
            if (beat1_q) begin
                win_col <= col1_q;
                win_row <= row1_q;
            end
            lbuf_clr   <= vs_rise;
        end
    end

    assign frame_done = (state_q == StDone);
    assign state_o    = state_q;

`ifdef LBUF_CTRL_LEN_CHECK_EN
    logic err_len_q;
    logic in_frame;

    assign in_frame = (state_q == StFill) || (state_q == StRun);

    always_ff @(posedge clk) begin
        if (rst || vs_rise) begin
            err_len_q <= 1'b0;
        end else if (hs_fall && in_frame && col_cnt_q != CNT_W'(IMG_H)) begin
            err_len_q <= 1'b1;
        end else if (state_q == StDone && row_cnt_q != CNT_W'(IMG_V)) begin
            err_len_q <= 1'b1;
        end
    end

    assign err_len = err_len_q;
`else
    assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: directed frames plus randomized line lengths and
// pixel qualifiers, compared each cycle against a frame/line/pixel reference model.
module tb_line_buffer_ctrl;

    localparam int unsigned IMG_H = 8;
    localparam int unsigned IMG_V = 4;
    localparam int unsigned CNT_W = 11;
    localparam int          SAT   = (1 << CNT_W) - 1;
    localparam int          DEPTH = 16384;
`ifdef LBUF_CTRL_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             pre_vs;
    logic             pre_hs;
    logic             pre_clken;
    logic             lbuf_clr;
    logic             win_valid;
    logic             win_border;
    logic [CNT_W-1:0] win_col;
    logic [CNT_W-1:0] win_row;
    logic             frame_done;
    logic [1:0]       state_o;
    logic             err_len;

    line_buffer_ctrl #(
        .IMG_H (IMG_H),
        .IMG_V (IMG_V),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pre_vs     (pre_vs),
        .pre_hs     (pre_hs),
        .pre_clken  (pre_clken),
        .lbuf_clr   (lbuf_clr),
        .win_valid  (win_valid),
        .win_border (win_border),
        .win_col    (win_col),
        .win_row    (win_row),
        .frame_done (frame_done),
        .state_o    (state_o),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected outputs indexed by cycle number.
    bit exp_v    [DEPTH];
    bit exp_b    [DEPTH];
    bit exp_clr  [DEPTH];
    bit exp_done [DEPTH];
    int exp_col  [DEPTH];
    int exp_row  [DEPTH];

    // Model: frame in progress, completed rows, pixels in current line, sticky error.
    bit live  = 1'b0;
    bit m_err = 1'b0;
    bit pv_vs = 1'b0;
    bit pv_hs = 1'b0;
    int y     = 0;
    int len   = 0;

    int cnt_v, cnt_b, cnt_clr, cnt_done, max_col;
    int q[$];
    int tbl[7] = '{8, 8, 8, 7, 9, 0, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clr_cnt();
        cnt_v    = 0;
        cnt_b    = 0;
        cnt_clr  = 0;
        cnt_done = 0;
        max_col  = 0;
    endtask

    task automatic step(input bit vs, input bit hs, input bit ck, input bit r);
        bit valid;
        int st;
        pre_vs    = vs;
        pre_hs    = hs;
        pre_clken = ck;
        rst       = r;
        @(posedge clk);
        cyc++;
        if (cyc + 2 >= DEPTH) begin
            $display("FAIL cycle_budget: cycle %0d reached model depth %0d", cyc, DEPTH);
            $fatal(1, "model depth exceeded");
        end
        if (r) begin
            live       = 1'b0;
            m_err      = 1'b0;
            len        = 0;
            exp_v[cyc] = 1'b0;
            exp_b[cyc] = 1'b0;
        end else begin
            if (hs && ck) begin
                valid          = live && y >= 2 && y < int'(IMG_V) && len >= 2;
                exp_v[cyc+1]   = valid;
                exp_b[cyc+1]   = !valid;
                exp_col[cyc+1] = len - 1;
                exp_row[cyc+1] = y - 1;
                if (len < SAT) len++;
            end
            if (vs && !pv_vs) begin
                live         = 1'b1;
                y            = 0;
                len          = 0;
                m_err        = 1'b0;
                exp_clr[cyc] = 1'b1;
            end else begin
                if (!hs && pv_hs) begin
                    if (LEN_EN && live && len != int'(IMG_H)) m_err = 1'b1;
                    if (len != 0) begin
                        y++;
                        if (live && y == int'(IMG_V)) begin
                            exp_done[cyc] = 1'b1;
                            live          = 1'b0;
                        end
                    end
                    len = 0;
                end
                if (!vs && pv_vs) live = 1'b0;
            end
        end
        pv_vs = vs;
        pv_hs = hs;
        #1;
        st = exp_done[cyc] ? 3 : (!live ? 0 : (y < 2 ? 1 : 2));
        chk("win_valid",  32'(win_valid),  32'(exp_v[cyc]));
        chk("win_border", 32'(win_border), 32'(exp_b[cyc]));
        chk("lbuf_clr",   32'(lbuf_clr),   32'(exp_clr[cyc]));
        chk("frame_done", 32'(frame_done), 32'(exp_done[cyc]));
        chk("state_o",    32'(state_o),    32'(st));
        chk("err_len",    32'(err_len),    32'(m_err));
        if (exp_v[cyc]) begin
            chk("win_col", 32'(win_col), 32'(exp_col[cyc]));
            chk("win_row", 32'(win_row), 32'(exp_row[cyc]));
        end
        if (r) begin
            chk("rst_win_col", 32'(win_col), 32'd0);
            chk("rst_win_row", 32'(win_row), 32'd0);
        end
        cnt_v    += int'(win_valid);
        cnt_b    += int'(win_border);
        cnt_clr  += int'(lbuf_clr);
        cnt_done += int'(frame_done);
        if (win_valid && int'(win_col) > max_col) max_col = int'(win_col);
    endtask

    task automatic line(input int n, input int mode);
        int sent = 0;
        bit ph   = 1'b1;
        bit ck;
        if (n == 0) repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        while (sent < n) begin
            case (mode)
                0:       ck = 1'b1;
                1:       begin ck = ph; ph = !ph; end
                default: ck = 1'($urandom_range(0, 1));
            endcase
            step(1'b1, 1'b1, ck, 1'b0);
            if (ck) sent++;
        end
        repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int lens[$], input int mode);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (lens[i]) line(lens[i], mode);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pre_vs    = 1'b0;
        pre_hs    = 1'b0;
        pre_clken = 1'b0;
        rst       = 1'b1;
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Clean frame, pixel every cycle.
        clr_cnt();
        q = {8, 8, 8, 8};
        frame(q, 0);
        chk("t2_valid_cnt",  32'(cnt_v),    32'd12);
        chk("t2_border_cnt", 32'(cnt_b),    32'd20);
        chk("t2_clr_cnt",    32'(cnt_clr),  32'd1);
        chk("t2_done_cnt",   32'(cnt_done), 32'd1);
        chk("t2_max_col",    32'(max_col),  32'd6);

        // Same frame, pixel every other cycle.
        clr_cnt();
        frame(q, 1);
        chk("t3_valid_cnt",  32'(cnt_v),    32'd12);
        chk("t3_border_cnt", 32'(cnt_b),    32'd20);
        chk("t3_done_cnt",   32'(cnt_done), 32'd1);

        // Reset held 5 cycles mid-line; the frame must not resume.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        line(8, 0);
        line(8, 0);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b1);
        clr_cnt();
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        line(8, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_clr_cnt",   32'(cnt_clr),  32'd0);
        chk("t1_valid_cnt", 32'(cnt_v),    32'd0);
        chk("t1_done_cnt",  32'(cnt_done), 32'd0);

        // Restart during row 2, with vs_rise coinciding with hs_fall.
        clr_cnt();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        line(8, 0);
        line(8, 0);
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_state_fill", 32'(state_o),  32'd1);
        chk("t4_done_none",  32'(cnt_done), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (q[i]) line(q[i], 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_clr_cnt",   32'(cnt_clr),  32'd2);
        chk("t4_valid_cnt", 32'(cnt_v),    32'd15);
        chk("t4_done_cnt",  32'(cnt_done), 32'd1);

        // Short line 1; error (when enabled) sticks until the next frame start.
        clr_cnt();
        q = {8, 7, 8, 8};
        frame(q, 0);
        chk("t5_err_len",   32'(err_len), 32'(LEN_EN));
        chk("t5_valid_cnt", 32'(cnt_v),   32'd12);
        q = {8, 8, 8, 8};
        frame(q, 2);
        chk("t5_err_clear", 32'(err_len), 32'd0);

        // Random line lengths (incl. empty and extra lines) and random pixel qualifiers.
        repeat (6) begin
            q.delete();
            repeat ($urandom_range(3, 6)) q.push_back(tbl[$urandom_range(0, 6)]);
            frame(q, int'($urandom_range(0, 2)));
        end

        // Over-long row 2 drives the column counter into saturation.
        clr_cnt();
        q = {8, 8, 2100, 8};
        frame(q, 0);
        chk("sat_max_col",  32'(max_col), 32'(SAT - 1));
        chk("sat_done_cnt", 32'(cnt_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
